nap_protocol_seq: RTL and testbench

- Cycle-accurate control sequencer for the SIZE-channel nucleic-acid processor chip.
- Drives the pneumatic valve lines (lysis, wash, elute, waste, per-channel collect) and the 3-valve peristaltic pump.
- Runs one extraction protocol per start: LYSIS, WASH, ELUTE into a selected collect channel, then FLUSH.
- Sits between the host command interface and the chip's ctrl pins; replaces hand-sequenced valve toggling.

---
 rtl/nap_protocol_seq.sv | 187 ++++++++++++++++++
 tb/tb_nap_protocol_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/nap_protocol_seq.sv
`default_nettype none
// ============================================================================
// Module   : nap_protocol_seq
// Function : Valve and pump sequencer for one LYSIS/WASH/ELUTE/FLUSH protocol.
// Revision : 1.0 - initial release
// ============================================================================
module nap_protocol_seq #(
    parameter int SIZE         = 7,
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 64,
    parameter int CH_W         = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CH_W-1:0]  chan,
    input  logic [CNT_W-1:0] lysis_cycles,
    input  logic [CNT_W-1:0] wash_cycles,
    input  logic [CNT_W-1:0] elute_cycles,
    input  logic [CNT_W-1:0] pump_period,
    output logic             lysis_ctrl,
    output logic             wash_ctrl,
    output logic             elute_ctrl,
    output logic             waste_ctrl,
    output logic [SIZE-1:0]  collect_ctrl,
    output logic [2:0]       pump,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_lysis = 3'd1;
    localparam logic [2:0] c_wash  = 3'd2;
    localparam logic [2:0] c_elute = 3'd3;
    localparam logic [2:0] c_flush = 3'd4;
    localparam logic [2:0] c_done  = 3'd5;

    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_flush_last = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CH_W:0]    c_size       = (CH_W + 1)'(SIZE);
    localparam logic [SIZE-1:0]  c_one_hot    = SIZE'(1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pcnt;
    logic [1:0]       r_phase;
    logic [CNT_W-1:0] r_lysis;
    logic [CNT_W-1:0] r_wash;
    logic [CNT_W-1:0] r_elute;
    logic [CNT_W-1:0] r_per_last;
    logic [CH_W-1:0]  r_chan;
    logic             r_err;

    logic [2:0]       w_nstate;
    logic             w_load;
    logic             w_reject;
    logic             w_entry;
    logic [CNT_W-1:0] w_ncnt;
    logic [CNT_W-1:0] w_npcnt;
    logic [1:0]       w_nphase;
    logic [CNT_W-1:0] w_per_last_n;
    logic [CH_W-1:0]  w_chan_n;
    logic             w_pumped;

    // Zero-length dwells are skipped within the same cycle, so the FSM lands
    // directly on the first state that actually has cycles to spend.
    function automatic logic [2:0] f_after_lysis(input logic [CNT_W-1:0] w,
                                                 input logic [CNT_W-1:0] e);
        logic [2:0] s;
        if (w != '0)      s = c_wash;
        else if (e != '0) s = c_elute;
        else              s = c_flush;
        return s;
    endfunction

    function automatic logic [2:0] f_first(input logic [CNT_W-1:0] l,
                                           input logic [CNT_W-1:0] w,
                                           input logic [CNT_W-1:0] e);
        return (l != '0) ? c_lysis : f_after_lysis(w, e);
    endfunction

    function automatic logic [2:0] f_pump(input logic [1:0] ph);
        logic [2:0] p;
        case (ph)
            2'd0:    p = 3'b110;
            2'd1:    p = 3'b011;
            default: p = 3'b101;
        endcase
        return p;
    endfunction

    always_comb begin
        w_load   = 1'b0;
        w_reject = 1'b0;
        w_nstate = r_state;
        case (r_state)
            c_idle: begin
                if (start) begin
                    if ({1'b0, chan} < c_size) begin
                        w_load   = 1'b1;
                        w_nstate = f_first(lysis_cycles, wash_cycles, elute_cycles);
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            c_lysis: if (r_cnt == r_lysis - c_one) w_nstate = f_after_lysis(r_wash, r_elute);
            c_wash:  if (r_cnt == r_wash - c_one)  w_nstate = (r_elute != '0) ? c_elute : c_flush;
            c_elute: if (r_cnt == r_elute - c_one) w_nstate = c_flush;
            c_flush: if (r_cnt == c_flush_last)    w_nstate = c_done;
            default: w_nstate = c_idle;
        endcase
        if (abort && (r_state != c_idle)) w_nstate = c_idle;

        w_entry      = (w_nstate != r_state);
        w_ncnt       = (w_entry || (r_state == c_idle)) ? '0 : r_cnt + c_one;
        w_chan_n     = w_load ? chan : r_chan;
        w_per_last_n = r_per_last;
        if (w_load) w_per_last_n = (pump_period == '0) ? '0 : pump_period - c_one;

        // Pump phase restarts at 3'b110 whenever a new state is entered.
        w_npcnt  = r_pcnt + c_one;
        w_nphase = r_phase;
        if (w_entry) begin
            w_npcnt  = '0;
            w_nphase = 2'd0;
        end else if (r_pcnt == r_per_last) begin
            w_npcnt  = '0;
            w_nphase = (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
        end
        w_pumped = (w_nstate >= c_lysis) && (w_nstate <= c_flush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_idle;
            r_cnt        <= '0;
            r_pcnt       <= '0;
            r_phase      <= 2'd0;
            r_lysis      <= '0;
            r_wash       <= '0;
            r_elute      <= '0;
            r_per_last   <= '0;
            r_chan       <= '0;
            r_err        <= 1'b0;
            lysis_ctrl   <= 1'b0;
            wash_ctrl    <= 1'b0;
            elute_ctrl   <= 1'b0;
            waste_ctrl   <= 1'b0;
            collect_ctrl <= '0;
            pump         <= 3'b000;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_state    <= w_nstate;
            r_cnt      <= w_ncnt;
            r_pcnt     <= w_npcnt;
            r_phase    <= w_nphase;
            r_per_last <= w_per_last_n;
            r_chan     <= w_chan_n;
            if (w_load) begin
                r_lysis <= lysis_cycles;
                r_wash  <= wash_cycles;
                r_elute <= elute_cycles;
                r_err   <= 1'b0;
            end else if (w_reject) begin
                r_err   <= 1'b1;
            end
            lysis_ctrl   <= (w_nstate == c_lysis);
            wash_ctrl    <= (w_nstate == c_wash) || (w_nstate == c_flush);
            elute_ctrl   <= (w_nstate == c_elute);
            waste_ctrl   <= (w_nstate == c_lysis) || (w_nstate == c_wash) || (w_nstate == c_flush);
            collect_ctrl <= (w_nstate == c_elute) ? (c_one_hot << w_chan_n) : '0;
            pump         <= w_pumped ? f_pump(w_nphase) : 3'b000;
            busy         <= (w_nstate != c_idle);
            done         <= (w_nstate == c_done);
        end
    end

    assign state = r_state;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nap_protocol_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_nap_protocol_seq
// Function : Scoreboard bench for nap_protocol_seq against a trace-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nap_protocol_seq;

    localparam int SIZE = 7;

    typedef struct packed {
        logic [2:0] st;
        logic       ly;
        logic       wa;
        logic       el;
        logic       ws;
        logic [6:0] col;
        logic [2:0] pm;
        logic       dn;
        logic       er;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [2:0]  chan;
    logic [15:0] lysis_cycles, wash_cycles, elute_cycles, pump_period;
    logic        lysis_ctrl, wash_ctrl, elute_ctrl, waste_ctrl, busy, done, err;
    logic [6:0]  collect_ctrl;
    logic [2:0]  pump, state;

    nap_protocol_seq #(.SIZE(SIZE), .CNT_W(16), .FLUSH_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .chan(chan),
        .lysis_cycles(lysis_cycles), .wash_cycles(wash_cycles),
        .elute_cycles(elute_cycles), .pump_period(pump_period),
        .lysis_ctrl(lysis_ctrl), .wash_ctrl(wash_ctrl), .elute_ctrl(elute_ctrl),
        .waste_ctrl(waste_ctrl), .collect_ctrl(collect_ctrl), .pump(pump),
        .busy(busy), .done(done), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    logic exp_err  = 1'b0;
    obs_t q_exp[$];
    obs_t q_tr[$];

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got st=%0d ly=%b wa=%b el=%b ws=%b col=%b pm=%b dn=%b er=%b, want st=%0d ly=%b wa=%b el=%b ws=%b col=%b pm=%b dn=%b er=%b",
                     name, $time, act.st, act.ly, act.wa, act.el, act.ws, act.col, act.pm, act.dn, act.er,
                     exp.st, exp.ly, exp.wa, exp.el, exp.ws, exp.col, exp.pm, exp.dn, exp.er);
        end
    endtask

    // Reference: expand a protocol into its per-cycle valve picture.
    task automatic build(input int ch, input int l, input int w, input int e, input int pp);
        int   dw[4];
        int   per;
        obs_t o;
        dw  = '{l, w, e, 64};
        per = (pp == 0) ? 1 : pp;
        q_tr.delete();
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < dw[s]; i++) begin
                o    = '0;
                o.st = 3'(s + 1);
                case (s)
                    0:       begin o.ly = 1'b1; o.ws = 1'b1; end
                    2:       begin o.el = 1'b1; o.col = 7'(1 << ch); end
                    default: begin o.wa = 1'b1; o.ws = 1'b1; end
                endcase
                case ((i / per) % 3)
                    0:       o.pm = 3'b110;
                    1:       o.pm = 3'b011;
                    default: o.pm = 3'b101;
                endcase
                q_tr.push_back(o);
            end
        end
        o    = '0;
        o.st = 3'd5;
        o.dn = 1'b1;
        q_tr.push_back(o);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = run to completion, 1 = abort at busy cycle k, 2 = reset at busy cycle k
    task automatic run(input int ch, input int l, input int w, input int e, input int pp,
                       input int kind, input int k);
        int   n;
        obs_t act;
        start        = 1'b1;
        chan         = 3'(ch);
        lysis_cycles = 16'(l);
        wash_cycles  = 16'(w);
        elute_cycles = 16'(e);
        pump_period  = 16'(pp);
        if (ch >= SIZE) begin
            step();
            start   = 1'b0;
            exp_err = 1'b1;
            step();
            return;
        end
        build(ch, l, w, e, pp);
        n = q_tr.size();
        if (kind != 0) begin
            if (k < 0) k = $urandom_range(0, n - 1);
            n = k + 1;
        end
        for (int i = 0; i < n; i++) q_exp.push_back(q_tr[i]);
        step();
        start   = 1'b0;
        exp_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            // Starts presented while busy must be ignored and must not disturb the latched set-up.
            start        = 1'($urandom_range(0, 1));
            chan         = 3'($urandom_range(0, 7));
            lysis_cycles = 16'($urandom_range(0, 9));
            wash_cycles  = 16'($urandom_range(0, 9));
            elute_cycles = 16'($urandom_range(0, 9));
            pump_period  = 16'($urandom_range(0, 3));
            if (i == n - 1 && kind == 1) begin
                abort = 1'b1;
                start = 1'b1;
            end
            if (i == n - 1 && kind == 2) rst = 1'b1;
            if (i == n - 1) start = (kind == 1);
            step();
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
        end
        act    = '0;
        act.st = 3'(q_exp.size() > 7 ? 7 : q_exp.size());
        chk("queue_drain", act, obs_t'(0));
        q_exp.delete();
    endtask

    always @(negedge clk) begin
        obs_t act, exp;
        if (mon_en) begin
            act = '{st: state, ly: lysis_ctrl, wa: wash_ctrl, el: elute_ctrl, ws: waste_ctrl,
                    col: collect_ctrl, pm: pump, dn: done, er: err};
            if (busy) begin
                if (q_exp.size() == 0) begin
                    exp    = '0;
                    exp.er = exp_err;
                    chk("unexpected_busy", act, exp);
                end else begin
                    exp = q_exp.pop_front();
                    chk("busy_cycle", act, exp);
                end
            end else begin
                exp    = '0;
                exp.er = exp_err;
                chk("idle_cycle", act, exp);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; chan = '0;
        lysis_cycles = '0; wash_cycles = '0; elute_cycles = '0; pump_period = '0;
        step();
        mon_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        run(3, 4, 2, 5, 2, 0, 0);
        run(7, 1, 1, 1, 1, 0, 0);
        step();
        run(1, 1, 2, 1, 1, 0, 0);
        run(5, 0, 0, 3, 0, 0, 0);
        run(4, 4, 3, 5, 1, 1, 5);
        run(6, 3, 2, 2, 3, 0, 0);
        run(2, 2, 2, 6, 1, 2, 7);
        run(0, 0, 0, 0, 2, 0, 0);

        for (int t = 0; t < 30; t++) begin
            run($urandom_range(0, 7), $urandom_range(0, 10), $urandom_range(0, 10),
                $urandom_range(0, 10), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? 1 : 0, -1);
            if ($urandom_range(0, 1) == 1) step();
        end

        run(6, 1, 1, 16'hFFFF, 2, 0, 0);
        repeat (3) step();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
